// File: rtl/sfr_bus_pkg.sv
// Shared definitions for the SFR debug bus arbiter: state encodings and default widths.
package sfr_bus_pkg;

  localparam int unsigned SFR_ADDR_W = 16;
  localparam int unsigned SFR_DATA_W = 8;

  // One-hot access sequencer states
  typedef enum logic [4:0] {
    ST_IDLE    = 5'h01,
    ST_WR      = 5'h02,
    ST_RD_EN   = 5'h04,
    ST_RD_WAIT = 5'h08,
    ST_DONE    = 5'h10
  } state_t;

endpackage

// File: rtl/sfr_rr_pick.sv
// Combinational winner select for the two SFR bus masters.
// A held lock restricts the choice to the current owner; otherwise both
// requesting masters are resolved round-robin in favour of the non-owner.
module sfr_rr_pick (
  input  logic req0,
  input  logic req1,
  input  logic owner,
  input  logic lock_act,
  input  logic lock_expired,
  output logic grant_valid,
  output logic grant_idx
);

  // Pick the winner from the current requests, owner and lock state
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = owner;
    if (lock_act && !lock_expired) begin
      grant_valid = owner ? req1 : req0;
      grant_idx   = owner;
    end else if (req0 && req1) begin
      // An expired lock also lands here, which hands the bus to the other master
      grant_valid = 1'b1;
      grant_idx   = ~owner;
    end else if (req0) begin
      grant_valid = 1'b1;
      grant_idx   = 1'b0;
    end else if (req1) begin
      grant_valid = 1'b1;
      grant_idx   = 1'b1;
    end
  end

endmodule

// File: rtl/sfr_bus_arbiter.sv
// Shares the SFR debug bus between the UART debug controller (m0) and the
// on-chip sequencer (m1). Each access becomes a one-cycle d_set (write) or a
// one-cycle d_enable followed by a delayed d_rdata sample (read).
// RD_WAIT must be at least 1; MAX_LOCK must be at least 1.
module sfr_bus_arbiter
  import sfr_bus_pkg::*;
#(
  parameter int unsigned ADDR_W   = SFR_ADDR_W,
  parameter int unsigned DATA_W   = SFR_DATA_W,
  parameter int unsigned RD_WAIT  = 1,
  parameter int unsigned MAX_LOCK = 64
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic              m0_lock,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic              m1_lock,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] d_address,
  output logic              d_set,
  output logic              d_enable,
  output logic [DATA_W-1:0] d_wdata,
  input  logic [DATA_W-1:0] d_rdata,
  output logic              owner,
  output logic              busy
);

  localparam int unsigned LOCK_W = $clog2(MAX_LOCK + 1);
  localparam int unsigned WAIT_W = $clog2(RD_WAIT + 1);

  state_t              state, state_n;
  logic [LOCK_W-1:0]   lock_cnt, lock_cnt_n;
  logic                lock_act, lock_act_n;
  logic [WAIT_W-1:0]   wait_cnt, wait_n;
  logic                m0_ack_n, m1_ack_n;
  logic [DATA_W-1:0]   m0_rdata_n, m1_rdata_n;
  logic [ADDR_W-1:0]   d_address_n;
  logic [DATA_W-1:0]   d_wdata_n;
  logic                d_set_n, d_enable_n, owner_n, busy_n;

  logic                owner_lock, lock_hold, lock_expired;
  logic                grant_valid, grant_idx;
  logic                g_we, g_lock;
  logic [ADDR_W-1:0]   g_addr;
  logic [DATA_W-1:0]   g_wdata;

  // Lock is only honoured while the owner still asserts it and the budget remains
  assign owner_lock   = owner ? m1_lock : m0_lock;
  assign lock_hold    = lock_act & owner_lock;
  assign lock_expired = (lock_cnt == LOCK_W'(MAX_LOCK));

  assign g_we    = grant_idx ? m1_we    : m0_we;
  assign g_lock  = grant_idx ? m1_lock  : m0_lock;
  assign g_addr  = grant_idx ? m1_addr  : m0_addr;
  assign g_wdata = grant_idx ? m1_wdata : m0_wdata;

  sfr_rr_pick u_pick (
    .req0         (m0_req),
    .req1         (m1_req),
    .owner        (owner),
    .lock_act     (lock_hold),
    .lock_expired (lock_expired),
    .grant_valid  (grant_valid),
    .grant_idx    (grant_idx)
  );

  // Next-state and next-output decode for the access sequencer
  always_comb begin
    state_n     = state;
    lock_cnt_n  = lock_cnt;
    lock_act_n  = lock_act;
    wait_n      = wait_cnt;
    m0_ack_n    = 1'b0;
    m1_ack_n    = 1'b0;
    m0_rdata_n  = m0_rdata;
    m1_rdata_n  = m1_rdata;
    d_address_n = d_address;
    d_wdata_n   = d_wdata;
    d_set_n     = 1'b0;
    d_enable_n  = 1'b0;
    owner_n     = owner;
    unique case (state)
      ST_IDLE: begin
        if (!owner_lock || lock_expired) lock_act_n = 1'b0;
        if (grant_valid) begin
          owner_n     = grant_idx;
          d_address_n = g_addr;
          d_wdata_n   = g_wdata;
          lock_act_n  = g_lock;
          if (grant_idx != owner) begin
            lock_cnt_n = g_lock ? LOCK_W'(1) : '0;
          end else if (g_lock && !lock_expired) begin
            lock_cnt_n = lock_cnt + LOCK_W'(1);
          end
          if (g_we) begin
            state_n = ST_WR;
            d_set_n = 1'b1;
          end else begin
            state_n    = ST_RD_EN;
            d_enable_n = 1'b1;
          end
        end
      end
      ST_WR: begin
        state_n = ST_DONE;
        if (owner) m1_ack_n = 1'b1;
        else       m0_ack_n = 1'b1;
      end
      ST_RD_EN: begin
        state_n = ST_RD_WAIT;
        wait_n  = WAIT_W'(RD_WAIT - 1);
      end
      ST_RD_WAIT: begin
        if (wait_cnt == '0) begin
          state_n = ST_DONE;
          if (owner) begin
            m1_rdata_n = d_rdata;
            m1_ack_n   = 1'b1;
          end else begin
            m0_rdata_n = d_rdata;
            m0_ack_n   = 1'b1;
          end
        end else begin
          wait_n = wait_cnt - WAIT_W'(1);
        end
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
    busy_n = (state_n != ST_IDLE);
  end

  // State, counters and all outputs are registered; reset aborts any access
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= ST_IDLE;
      lock_cnt  <= '0;
      lock_act  <= 1'b0;
      wait_cnt  <= '0;
      m0_ack    <= 1'b0;
      m1_ack    <= 1'b0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
      d_address <= '0;
      d_wdata   <= '0;
      d_set     <= 1'b0;
      d_enable  <= 1'b0;
      owner     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      lock_cnt  <= lock_cnt_n;
      lock_act  <= lock_act_n;
      wait_cnt  <= wait_n;
      m0_ack    <= m0_ack_n;
      m1_ack    <= m1_ack_n;
      m0_rdata  <= m0_rdata_n;
      m1_rdata  <= m1_rdata_n;
      d_address <= d_address_n;
      d_wdata   <= d_wdata_n;
      d_set     <= d_set_n;
      d_enable  <= d_enable_n;
      owner     <= owner_n;
      busy      <= busy_n;
    end
  end

endmodule

// File: tb/tb_sfr_bus_arbiter.sv
// Directed bench for sfr_bus_arbiter: a table of single accesses plus
// hand-written round-robin, lock, reset-abort and withdrawn-request sequences.
module tb_sfr_bus_arbiter;

  localparam int unsigned AW   = 16;
  localparam int unsigned DW   = 8;
  localparam int unsigned RDW  = 1;
  localparam int unsigned MAXL = 4;

  typedef struct {
    logic          mst;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
  } vec_t;

  logic                sys_clk = 1'b0;
  logic                sys_rst_n;
  logic [1:0]          req, we, lock;
  logic [1:0][AW-1:0]  addr;
  logic [1:0][DW-1:0]  wdata;
  logic                m0_ack, m1_ack;
  logic [DW-1:0]       m0_rdata, m1_rdata;
  logic [AW-1:0]       d_address;
  logic                d_set, d_enable;
  logic [DW-1:0]       d_wdata, d_rdata;
  logic                owner, busy;

  int unsigned         nvec = 0;
  int unsigned         nmis = 0;
  logic [DW-1:0]       exp_rd [2];
  vec_t                vecs [6];

  sfr_bus_arbiter #(
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .RD_WAIT  (RDW),
    .MAX_LOCK (MAXL)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .m0_req    (req[0]),
    .m0_we     (we[0]),
    .m0_lock   (lock[0]),
    .m0_addr   (addr[0]),
    .m0_wdata  (wdata[0]),
    .m0_ack    (m0_ack),
    .m0_rdata  (m0_rdata),
    .m1_req    (req[1]),
    .m1_we     (we[1]),
    .m1_lock   (lock[1]),
    .m1_addr   (addr[1]),
    .m1_wdata  (wdata[1]),
    .m1_ack    (m1_ack),
    .m1_rdata  (m1_rdata),
    .d_address (d_address),
    .d_set     (d_set),
    .d_enable  (d_enable),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .owner     (owner),
    .busy      (busy)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic ack_of(input logic m);
    return m ? m1_ack : m0_ack;
  endfunction

  function automatic logic [DW-1:0] rdata_of(input logic m);
    return m ? m1_rdata : m0_rdata;
  endfunction

  task automatic tick();
    @(posedge sys_clk);
    @(negedge sys_clk);
  endtask

  task automatic do_reset();
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    req = '0; we = '0; lock = '0; addr = '0; wdata = '0; d_rdata = '0;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    tick();
    tick();
    sys_rst_n = 1'b1;
  endtask

  // One access from idle; cycle numbers count from the first posedge after the request
  task automatic run_vec(input vec_t v, input bit drop_early);
    int unsigned   set_c, en_c, ack_c, nstrobe, exp_ack;
    bit            both, other_ack;
    logic [AW-1:0] a_at;
    logic [DW-1:0] wd_at, rd_at;
    logic          own_at;
    set_c = 0; en_c = 0; ack_c = 0; nstrobe = 0; both = 0; other_ack = 0;
    a_at = '0; wd_at = '0; rd_at = '0; own_at = 1'b0;
    addr[v.mst] = v.addr; wdata[v.mst] = v.wdata; we[v.mst] = v.we;
    lock[v.mst] = 1'b0; d_rdata = v.rdata; req[v.mst] = 1'b1;
    for (int unsigned k = 1; k <= 20; k++) begin
      tick();
      if (d_set && d_enable) both = 1;
      if (d_set || d_enable) begin
        nstrobe++;
        if (nstrobe == 1) begin
          a_at = d_address; wd_at = d_wdata; own_at = owner;
        end
      end
      if (d_set && set_c == 0) set_c = k;
      if (d_enable && en_c == 0) en_c = k;
      if (ack_of(!v.mst)) other_ack = 1;
      if (drop_early && k == 1) req[v.mst] = 1'b0;
      if (ack_of(v.mst)) begin
        ack_c = k;
        rd_at = rdata_of(v.mst);
        req[v.mst] = 1'b0;
        break;
      end
    end
    exp_ack = v.we ? 2 : 2 + RDW;
    if (!v.we) exp_rd[v.mst] = v.rdata;
    chk("strobe_cycle", v.we ? set_c : en_c, 1);
    chk("wrong_strobe", v.we ? en_c : set_c, 0);
    chk("strobe_count", nstrobe, 1);
    chk("set_and_enable", both, 0);
    chk("d_address", a_at, v.addr);
    if (v.we) chk("d_wdata", wd_at, v.wdata);
    chk("owner", own_at, v.mst);
    chk("ack_cycle", ack_c, exp_ack);
    chk("other_ack", other_ack, 0);
    chk("rdata", rd_at, exp_rd[v.mst]);
    chk("rdata_other_held", rdata_of(!v.mst), exp_rd[!v.mst]);
    tick();
    chk("ack_single_pulse", ack_of(v.mst), 0);
    chk("idle_after", busy, 0);
  endtask

  // Locked m0 reads with m1 joining after the first grant
  task automatic lock_seq(input int unsigned nobs, input int unsigned drop_after,
                          input logic [4:0] exp_owners);
    int unsigned n;
    n = 0;
    do_reset();
    addr[0] = 16'h0010; we[0] = 1'b0; lock[0] = 1'b1; d_rdata = 8'h77; req[0] = 1'b1;
    for (int unsigned k = 1; k <= 80 && n < nobs; k++) begin
      tick();
      if (d_set || d_enable) begin
        chk("lock_owner", owner, exp_owners[n]);
        chk("lock_cycle", k, 1 + 4 * n);
        n++;
        if (n == 1) begin
          addr[1] = 16'h0020; wdata[1] = 8'h5C; we[1] = 1'b1; lock[1] = 1'b0; req[1] = 1'b1;
        end
        if (n == drop_after) lock[0] = 1'b0;
      end
    end
    chk("lock_grants_seen", n, nobs);
    req = '0; lock = '0;
    for (int unsigned k = 0; k < 20; k++) begin
      tick();
      if (!busy) break;
    end
  endtask

  initial begin
    int unsigned n, acks0, acks1, strobes, acks;
    logic        exp_o;

    vecs[0] = '{1'b0, 1'b1, 16'h1234, 8'hA5, 8'hEE};
    vecs[1] = '{1'b1, 1'b0, 16'h0040, 8'h00, 8'h3C};
    vecs[2] = '{1'b1, 1'b1, 16'hFFFF, 8'h00, 8'hEE};
    vecs[3] = '{1'b0, 1'b0, 16'h0000, 8'h00, 8'hFF};
    vecs[4] = '{1'b0, 1'b1, 16'h8001, 8'h5A, 8'h12};
    vecs[5] = '{1'b1, 1'b0, 16'hABCD, 8'h00, 8'h81};

    sys_rst_n = 1'b0;
    req = '0; we = '0; lock = '0; addr = '0; wdata = '0; d_rdata = '0;
    exp_rd[0] = '0;
    exp_rd[1] = '0;

    // Reset values
    #2;
    chk("rst_d_set", d_set, 0);
    chk("rst_d_enable", d_enable, 0);
    chk("rst_m0_ack", m0_ack, 0);
    chk("rst_m1_ack", m1_ack, 0);
    chk("rst_busy", busy, 0);
    chk("rst_owner", owner, 0);
    chk("rst_d_address", d_address, 0);
    chk("rst_d_wdata", d_wdata, 0);
    chk("rst_m0_rdata", m0_rdata, 0);
    chk("rst_m1_rdata", m1_rdata, 0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;

    // Table of single accesses
    for (int i = 0; i < 6; i++) run_vec(vecs[i], 1'b0);

    // Round-robin: both masters write continuously, m1 wins first after reset
    do_reset();
    addr[0] = 16'h0100; addr[1] = 16'h0200; wdata[0] = 8'h11; wdata[1] = 8'h22;
    we = 2'b11; lock = '0; req = 2'b11;
    n = 0; acks0 = 0; acks1 = 0;
    for (int unsigned k = 1; k <= 18; k++) begin
      tick();
      if (d_set) begin
        if (n < 6) begin
          exp_o = (n % 2 == 0);
          chk("rr_cycle", k, 1 + 3 * n);
          chk("rr_owner", owner, exp_o);
          chk("rr_addr", d_address, exp_o ? 16'h0200 : 16'h0100);
        end
        n++;
      end
      if (m0_ack) acks0++;
      if (m1_ack) acks1++;
    end
    req = '0;
    chk("rr_grants", n, 6);
    chk("rr_m0_acks", acks0, 3);
    chk("rr_m1_acks", acks1, 3);
    for (int unsigned k = 0; k < 10; k++) begin
      tick();
      if (!busy) break;
    end

    // Lock held to MAX_LOCK, then forced release; and lock dropped after 2nd access
    lock_seq(5, 0, 5'b10000);
    lock_seq(3, 2, 5'b00100);

    // Reset asserted during RD_WAIT of an m1 read; m0 request pending across reset
    do_reset();
    addr[1] = 16'h0300; we[1] = 1'b0; d_rdata = 8'h66; req[1] = 1'b1;
    tick();
    chk("abort_enable", d_enable, 1);
    tick();
    chk("abort_busy", busy, 1);
    chk("abort_owner", owner, 1);
    #2;
    sys_rst_n = 1'b0;
    req[1] = 1'b0;
    addr[0] = 16'h0055; we[0] = 1'b0; req[0] = 1'b1;
    #1;
    chk("abort_d_enable", d_enable, 0);
    chk("abort_d_set", d_set, 0);
    chk("abort_m1_ack", m1_ack, 0);
    chk("abort_busy_clr", busy, 0);
    chk("abort_owner_clr", owner, 0);
    chk("abort_d_address", d_address, 0);
    tick();
    tick();
    chk("abort_no_ack", {m1_ack, m0_ack}, 0);
    chk("abort_m1_rdata", m1_rdata, 0);
    sys_rst_n = 1'b1;
    run_vec('{1'b0, 1'b0, 16'h0055, 8'h00, 8'h99}, 1'b0);

    // Request withdrawn in cycle 1 of a read: one access, one ack
    do_reset();
    run_vec('{1'b1, 1'b0, 16'h0040, 8'h00, 8'h3C}, 1'b1);
    strobes = 0; acks = 0;
    for (int unsigned k = 0; k < 8; k++) begin
      tick();
      if (d_set || d_enable) strobes++;
      if (m1_ack) acks++;
    end
    chk("withdrawn_no_strobe", strobes, 0);
    chk("withdrawn_no_ack", acks, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/sfr_bus_arbiter.md
# sfr_bus_arbiter

Shares the single SFR debug bus (`d_address` / `d_set` / `d_enable` / data) between two masters. Master 0 is the UART debug controller; master 1 is the on-chip sequencer. Each access is serialised into the bus pulse protocol: a one-cycle `d_set` for writes, and a one-cycle `d_enable` plus a delayed sample for reads. Arbitration is round-robin, with an optional bounded burst lock so that multi-location reads and writes stay contiguous.

## Interface
- `ADDR_W`, default 16: SFR address width.
- `DATA_W`, default 8: SFR data width.
- `RD_WAIT`, default 1: cycles from the `d_enable` cycle to the `d_rdata` sample edge; minimum 1.
- `MAX_LOCK`, default 64: maximum consecutive locked grants to one master before a forced release.

Ports:
- `sys_clk` input 1: clock.
- `sys_rst_n` input 1: reset, asynchronous, active-low.
- `mN_req` input 1 (N=0,1): access request.
- `mN_we` input 1: 1 = write, 0 = read.
- `mN_lock` input 1: request to keep the grant after this access.
- `mN_addr` input ADDR_W: access address.
- `mN_wdata` input DATA_W: write data.
- `mN_ack` output 1: one-cycle completion pulse.
- `mN_rdata` output DATA_W: read data; valid while `mN_ack`=1, held until that master's next read ack.
- `d_address` output ADDR_W: SFR bus address.
- `d_set` output 1: one-cycle write strobe.
- `d_enable` output 1: one-cycle read strobe.
- `d_wdata` output DATA_W: SFR bus write data.
- `d_rdata` input DATA_W: SFR bus read data.
- `owner` output 1: index of the current or last granted master.
- `busy` output 1: high in any state other than IDLE.

## Operation
- All outputs are registered.
- Reset values:
  - `mN_ack`, `d_set`, `d_enable`, `busy`, `owner` = 0.
  - `d_address`, `d_wdata`, `mN_rdata` = 0.
  - State = IDLE; `lock_cnt` = 0; `lock_act` = 0.
- States, one-hot: IDLE, WR, RD_EN, RD_WAIT, DONE.
  - IDLE: evaluate requests. On a winner, latch `addr`/`we`/`wdata` into `d_address`/`d_wdata`, set `owner`, then go to WR (`d_set`<=1) or RD_EN (`d_enable`<=1).
  - WR → DONE. `d_set` drops and the winner's ack is raised.
  - RD_EN → RD_WAIT. `d_enable` drops; the wait counter loads RD_WAIT-1.
  - RD_WAIT: count down. At 0, capture `d_rdata` into `mN_rdata[owner]`, raise ack, go to DONE.
  - DONE → IDLE. Ack drops.
- Request rules:
  - `req` is sampled only in IDLE.
  - Once a request is latched, the access completes and is acked even if `req` falls.
  - A master must hold `req`/`addr`/`we`/`wdata` stable until its ack. Keeping `req` high in the cycle after the ack requests a new access.
- Arbitration:
  - Single request: grant it.
  - Both requesting: grant the master that is not `owner` (round-robin).
- Lock:
  - `lock_act` is set at grant when the winner's `mN_lock`=1.
  - While `lock_act`=1, IDLE considers only `owner`'s request. The other master waits even if the owner is idle.
  - `lock_cnt` increments on each locked grant and resets to 0 when the grant changes master.
  - Lock is released, with normal arbitration in the same IDLE cycle, when either:
    - `owner`'s `lock` is 0 while in IDLE, or
    - `lock_cnt` == MAX_LOCK; the next grant is then forced to the other master if it is requesting.
- `lock_cnt` width is clog2(MAX_LOCK+1) and it saturates; it never wraps.
- `d_address` and `d_wdata` hold their last values between accesses.
- `d_set` and `d_enable` are never high together.

## Timing
- Cycle 0 is the first cycle `req` is seen in IDLE.
- Write:
  - Cycle 1: `d_set`=1 with address and data valid.
  - Cycle 2: ack.
  - Cycle 3: IDLE.
  - Back-to-back writes: one every 3 cycles.
- Read:
  - Cycle 1: `d_enable`=1.
  - `d_rdata` is sampled at the end of cycle 1+RD_WAIT.
  - Cycle 2+RD_WAIT: ack with `rdata`.
  - Cycle 3+RD_WAIT: IDLE.
- Asynchronous reset mid-access aborts with no ack and no further strobe. After release the block starts in IDLE.

## Structure
- Shared package/header `sfr_bus_pkg`:
  - State encodings: IDLE=5'h01, WR=5'h02, RD_EN=5'h04, RD_WAIT=5'h08, DONE=5'h10.
  - Default ADDR_W and DATA_W.
- One sub-module, `sfr_rr_pick`: combinational winner select. Inputs: `req0`, `req1`, `owner`, `lock_act`, `lock_expired`. Outputs: `grant_valid`, `grant_idx`.
- Top level: FSM, lock counter, wait counter, output registers.

## Test plan
- **Single write:** m0 write addr 16'h1234, data 8'hA5 → `d_set`=1 in cycle 1 with `d_address`=16'h1234, `d_wdata`=8'hA5; `m0_ack` in cycle 2; `d_enable` stays 0.
- **Single read:** m1 read addr 16'h0040, `d_rdata`=8'h3C, RD_WAIT=1 → `d_enable` in cycle 1; `m1_ack` in cycle 3 with `m1_rdata`=8'h3C.
- **Round-robin:** m0 and m1 both hold write requests continuously → grants alternate m1,m0,m1,… (`owner` reset 0, so m1 first); each master acked once per 6 cycles.
- **Lock and force release:** m0 issues locked reads with MAX_LOCK=4 while m1 requests → exactly 4 m0 accesses, then m1 granted. With `m0_lock` dropped after the 2nd access, m1 is granted at the 3rd arbitration.
- **Reset mid-read:** `sys_rst_n` low during RD_WAIT → all outputs 0 immediately, no ack. After release, a pending m0 request completes normally.
- **Request withdrawn:** m1 drops `req` in cycle 1 of a read → access still completes and `m1_ack` pulses once; no second access.
